// File: rtl/inst_fetch_queue_if.sv
// Fetch-side bundle: instruction-memory request/response, execute-side redirect/halt,
// and the decoder valid/ready handshake. master = fetch queue, slave = surrounding core.
interface inst_fetch_queue_if #(
  parameter int unsigned PC_W = 8
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic [7:0]      imem_rdata;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            halt;
  logic            inst_valid;
  logic [7:0]      inst;
  logic [PC_W-1:0] inst_pc;
  logic            inst_ready;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_rdata, redirect_valid, redirect_pc, halt, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_rdata, redirect_valid, redirect_pc, halt, inst_ready
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch initiator with credit-based prefetch FIFO and redirect flush.
// Optional FETCH_PERF_CNT_EN adds a saturating decoder-starvation counter (stall_cnt).
module inst_fetch_queue #(
  parameter int unsigned     PC_W     = 8,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0]         stall_cnt,
`endif
  inst_fetch_queue_if.master  bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  fetch_pc_q;
  logic             inflight_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [7:0]       inst_mem_q [DEPTH];
  logic [PC_W-1:0]  pc_mem_q   [DEPTH];

  logic             req;
  logic             push;
  logic             pop;
  logic [CNT_W:0]   credit_used;

  // Queued entries plus the outstanding fetch must fit, so a push can never overflow.
  assign credit_used = {1'b0, count_q} + (CNT_W+1)'(inflight_q);
  assign req  = !reset && !bus.halt && !bus.redirect_valid &&
                (credit_used < (CNT_W+1)'(DEPTH));
  assign push = inflight_q && !bus.redirect_valid;
  assign pop  = (count_q != '0) && bus.inst_ready;

  always_comb begin
    pc_d     = pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (bus.redirect_valid) begin
      pc_d     = bus.redirect_pc;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (req)  pc_d     = pc_q + PC_W'(1);
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      fetch_pc_q <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= req;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      if (req) fetch_pc_q <= pc_q;
    end
  end

  // Each entry pairs the returned word with the address it was fetched from.
  for (genvar gi = 0; gi < int'(DEPTH); gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (reset) begin
        inst_mem_q[gi] <= '0;
        pc_mem_q[gi]   <= '0;
      end else if (push && (wr_ptr_q == PTR_W'(gi))) begin
        inst_mem_q[gi] <= bus.imem_rdata;
        pc_mem_q[gi]   <= fetch_pc_q;
      end
    end
  end

  assign bus.imem_req   = req;
  assign bus.imem_addr  = pc_q;
  assign bus.inst_valid = (count_q != '0);
  assign bus.inst       = inst_mem_q[rd_ptr_q];
  assign bus.inst_pc    = pc_mem_q[rd_ptr_q];

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt_q;

  // Counts cycles the decoder was ready but starved; survives redirects.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (bus.inst_ready && (count_q == '0) && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif
endmodule
